// File: rtl/mannix_ddr_line_writer.sv
// mannix_ddr_line_writer
//
// Write-back stage behind the memory farm's DDR write-request port. Line
// write requests (LINE_WIDTH bits) are queued in a FIFO_DEPTH-entry FIFO and
// issued one at a time to the DDR controller as: address phase (aw), BEATS
// data beats of DDR_DATA_WIDTH bits (w, least-significant slice first) and a
// write response (b). A one-cycle wr_done pulse follows each response.
//
// Optional feature macro: MANNIX_DDR_WR_MASK_EN
//   defined   - wr_req_mask port exists, byte enables are stored per entry and
//               drive ddr_w_strb beat by beat
//   undefined - no mask port/storage, ddr_w_strb is all ones during data beats
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   wr_req_valid/ready          upstream request handshake
//   wr_req_addr/data(/mask)     upstream line address, data (byte enables)
//   wr_done                     one-cycle pulse per completed line
//   ddr_aw_*                    burst address channel (len = BEATS-1)
//   ddr_w_*                     burst data channel
//   ddr_b_valid/ready/err       write response channel
//   err_clr, err_sticky         sticky error (misaligned address or DDR error)
//   busy                        FIFO non-empty or a line in flight
module mannix_ddr_line_writer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_WIDTH     = 256,
    parameter int DDR_DATA_WIDTH = 64,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_req_valid,
    output logic                          wr_req_ready,
    input  logic [ADDR_WIDTH-1:0]         wr_req_addr,
    input  logic [LINE_WIDTH-1:0]         wr_req_data,
`ifdef MANNIX_DDR_WR_MASK_EN
    input  logic [LINE_WIDTH/8-1:0]       wr_req_mask,
`endif
    output logic                          wr_done,
    output logic                          ddr_aw_valid,
    input  logic                          ddr_aw_ready,
    output logic [ADDR_WIDTH-1:0]         ddr_aw_addr,
    output logic [7:0]                    ddr_aw_len,
    output logic                          ddr_w_valid,
    input  logic                          ddr_w_ready,
    output logic [DDR_DATA_WIDTH-1:0]     ddr_w_data,
    output logic [DDR_DATA_WIDTH/8-1:0]   ddr_w_strb,
    output logic                          ddr_w_last,
    input  logic                          ddr_b_valid,
    input  logic                          ddr_b_err,
    output logic                          ddr_b_ready,
    input  logic                          err_clr,
    output logic                          err_sticky,
    output logic                          busy
);

    localparam int BEATS  = LINE_WIDTH / DDR_DATA_WIDTH;
    localparam int STRB_W = DDR_DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [PTR_W:0]    DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

    state_t state_reg, state_next;
    logic [BEAT_W-1:0] beat_reg, beat_next;
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]    count_reg, count_next;
    logic              push, pop, b_fire;

    // FIFO storage: written on push, read into the working registers on pop
    logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
    logic [LINE_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [LINE_WIDTH-1:0] work_data_reg;
    logic [DDR_DATA_WIDTH-1:0] data_beats [BEATS];

    logic                      aw_valid_reg, w_valid_reg, w_last_reg, b_ready_reg;
    logic                      wr_done_reg, err_sticky_reg, busy_reg;
    logic [ADDR_WIDTH-1:0]     aw_addr_reg;
    logic [DDR_DATA_WIDTH-1:0] w_data_reg;
    logic [STRB_W-1:0]         w_strb_reg;

    // Ready comes from the registered count, so a pop in the same cycle never
    // frees a slot early; it is also held low while reset is asserted.
    assign wr_req_ready = !rst && (count_reg != DEPTH_C);
    assign push         = wr_req_valid && wr_req_ready;
    assign count_next   = count_reg + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= wr_req_addr;
            data_mem[wr_ptr_reg] <= wr_req_data;
        end
        if (pop) begin
            work_data_reg <= data_mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            state_reg  <= ST_IDLE;
            beat_reg   <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
            state_reg <= state_next;
            beat_reg  <= beat_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        pop        = 1'b0;
        b_fire     = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    beat_next  = '0;
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ddr_aw_ready) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (ddr_w_ready) begin
                    if (beat_reg == LAST_BEAT) state_next = ST_RESP;
                    else                       beat_next  = beat_reg + BEAT_W'(1);
                end
            end
            ST_RESP: begin
                if (ddr_b_valid) begin
                    b_fire     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Beat k of the working line is slice k, least-significant first
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beats
        assign data_beats[gi] = work_data_reg[gi*DDR_DATA_WIDTH +: DDR_DATA_WIDTH];
    end

`ifdef MANNIX_DDR_WR_MASK_EN
    logic [LINE_WIDTH/8-1:0] mask_mem [FIFO_DEPTH];
    logic [LINE_WIDTH/8-1:0] work_mask_reg;
    logic [STRB_W-1:0]       strb_beats [BEATS];

    always_ff @(posedge clk) begin
        if (push) mask_mem[wr_ptr_reg] <= wr_req_mask;
        if (pop)  work_mask_reg <= mask_mem[rd_ptr_reg];
    end

    for (genvar gi = 0; gi < BEATS; gi++) begin : g_strb
        assign strb_beats[gi] = work_mask_reg[gi*STRB_W +: STRB_W];
    end
`endif

    // Outputs are registered from the next state, so each channel's valid
    // rises in the same cycle the FSM enters the matching state.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_valid_reg   <= 1'b0;
            w_valid_reg    <= 1'b0;
            w_last_reg     <= 1'b0;
            b_ready_reg    <= 1'b0;
            wr_done_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            err_sticky_reg <= 1'b0;
            aw_addr_reg    <= '0;
            w_data_reg     <= '0;
            w_strb_reg     <= '0;
        end else begin
            aw_valid_reg <= (state_next == ST_ADDR);
            w_valid_reg  <= (state_next == ST_DATA);
            w_last_reg   <= (state_next == ST_DATA) && (beat_next == LAST_BEAT);
            b_ready_reg  <= (state_next == ST_RESP);
            wr_done_reg  <= b_fire;
            busy_reg     <= (count_next != '0) || (state_next != ST_IDLE);
            // Low address bits below line granularity are dropped on the bus
            if (pop) begin
                aw_addr_reg <= {addr_mem[rd_ptr_reg][ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
            end
            w_data_reg <= (state_next == ST_DATA) ? data_beats[beat_next] : '0;
`ifdef MANNIX_DDR_WR_MASK_EN
            w_strb_reg <= (state_next == ST_DATA) ? strb_beats[beat_next] : '0;
`else
            w_strb_reg <= (state_next == ST_DATA) ? '1 : '0;
`endif
            // A new error event wins over a clear in the same cycle
            if ((pop && (|addr_mem[rd_ptr_reg][OFF_W-1:0])) || (b_fire && ddr_b_err)) begin
                err_sticky_reg <= 1'b1;
            end else if (err_clr) begin
                err_sticky_reg <= 1'b0;
            end
        end
    end

    assign ddr_aw_valid = aw_valid_reg;
    assign ddr_aw_addr  = aw_addr_reg;
    assign ddr_aw_len   = 8'(BEATS - 1);
    assign ddr_w_valid  = w_valid_reg;
    assign ddr_w_data   = w_data_reg;
    assign ddr_w_strb   = w_strb_reg;
    assign ddr_w_last   = w_last_reg;
    assign ddr_b_ready  = b_ready_reg;
    assign wr_done      = wr_done_reg;
    assign err_sticky   = err_sticky_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_mannix_ddr_line_writer.sv
module tb_mannix_ddr_line_writer;
    localparam int AW    = 32;
    localparam int LW    = 256;
    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int BEATS = LW / DW;
    localparam int OFF   = 5;

    logic clk = 1'b0;
    logic rst;
    logic wr_req_valid, wr_req_ready;
    logic [AW-1:0] wr_req_addr;
    logic [LW-1:0] wr_req_data;
`ifdef MANNIX_DDR_WR_MASK_EN
    logic [LW/8-1:0] wr_req_mask;
`endif
    logic wr_done;
    logic ddr_aw_valid, ddr_aw_ready;
    logic [AW-1:0] ddr_aw_addr;
    logic [7:0] ddr_aw_len;
    logic ddr_w_valid, ddr_w_ready, ddr_w_last;
    logic [DW-1:0] ddr_w_data;
    logic [DW/8-1:0] ddr_w_strb;
    logic ddr_b_valid, ddr_b_err, ddr_b_ready;
    logic err_clr, err_sticky, busy;

    mannix_ddr_line_writer dut (
        .clk(clk), .rst(rst),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
`ifdef MANNIX_DDR_WR_MASK_EN
        .wr_req_mask(wr_req_mask),
`endif
        .wr_done(wr_done),
        .ddr_aw_valid(ddr_aw_valid), .ddr_aw_ready(ddr_aw_ready),
        .ddr_aw_addr(ddr_aw_addr), .ddr_aw_len(ddr_aw_len),
        .ddr_w_valid(ddr_w_valid), .ddr_w_ready(ddr_w_ready),
        .ddr_w_data(ddr_w_data), .ddr_w_strb(ddr_w_strb), .ddr_w_last(ddr_w_last),
        .ddr_b_valid(ddr_b_valid), .ddr_b_err(ddr_b_err), .ddr_b_ready(ddr_b_ready),
        .err_clr(err_clr), .err_sticky(err_sticky), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [LW-1:0]   data;
        logic [LW/8-1:0] mask;
    } line_t;

    line_t exp_q[$];           // accepted lines, in issue order
    line_t cur;
    int    checks = 0;
    int    errors = 0;
    bit    in_data = 0;
    int    mon_beat = 0;
    bit    done_due = 0;
    bit    exp_err = 0;
    int    done_count = 0;
    int    t_acc, t_aw, t_beat0, t_last, t_bhs, t_done;
    int    mode = 0;           // 0 ready, 1 random, 2 aw stalled, 3 w toggling
    bit    force_berr = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // DDR controller model: readies change 1 time unit after each edge
    always @(posedge clk) begin
        #1;
        case (mode)
            1: begin
                ddr_aw_ready = 1'($urandom_range(0, 1));
                ddr_w_ready  = 1'($urandom_range(0, 1));
                ddr_b_valid  = 1'($urandom_range(0, 1));
                ddr_b_err    = ($urandom_range(0, 7) == 0);
            end
            2: begin
                ddr_aw_ready = 1'b0; ddr_w_ready = 1'b1; ddr_b_valid = 1'b1; ddr_b_err = force_berr;
            end
            3: begin
                ddr_aw_ready = 1'b1; ddr_w_ready = cyc[0]; ddr_b_valid = 1'b1; ddr_b_err = force_berr;
            end
            default: begin
                ddr_aw_ready = 1'b1; ddr_w_ready = 1'b1; ddr_b_valid = 1'b1; ddr_b_err = force_berr;
            end
        endcase
    end

    // Monitor: compares every DDR-side transfer and wr_done against the queue
    always @(negedge clk) begin
        if (rst) begin
            in_data  = 0;
            done_due = 0;
        end else begin
            if (wr_done || done_due) begin
                check("wr_done_pulse", wr_done, done_due);
                if (wr_done) begin
                    done_count++;
                    t_done = cyc;
                    check("err_at_done", err_sticky, exp_err);
                    $display("line done #%0d at cycle %0d err_sticky=%0b", done_count, cyc, err_sticky);
                end
            end
            done_due = ddr_b_valid && ddr_b_ready;
            if (done_due) begin
                exp_err |= ddr_b_err;
                t_bhs = cyc;
                check("beats_per_line", mon_beat, BEATS);
            end
            if (ddr_aw_valid && ddr_aw_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL aw_unexpected: got addr %0h expected no burst", ddr_aw_addr);
                end else begin
                    cur = exp_q.pop_front();
                    check("aw_addr", ddr_aw_addr, {cur.addr[AW-1:OFF], 5'd0});
                    check("aw_len", ddr_aw_len, BEATS - 1);
                    if (cur.addr[OFF-1:0] != 0) exp_err = 1;
                    check("err_at_aw", err_sticky, exp_err);
                    in_data  = 1;
                    mon_beat = 0;
                    t_aw     = cyc;
                end
            end
            if (ddr_w_valid) begin
                if (!in_data) begin
                    checks++;
                    errors++;
                    $display("FAIL w_without_aw: got w_valid 1 expected 0");
                end else begin
                    check("w_data", ddr_w_data, cur.data[mon_beat*DW +: DW]);
`ifdef MANNIX_DDR_WR_MASK_EN
                    check("w_strb", ddr_w_strb, cur.mask[mon_beat*(DW/8) +: DW/8]);
`else
                    check("w_strb", ddr_w_strb, {(DW/8){1'b1}});
`endif
                    check("w_last", ddr_w_last, (mon_beat == BEATS - 1));
                    if (ddr_w_ready) begin
                        if (mon_beat == 0) t_beat0 = cyc;
                        if (mon_beat == BEATS - 1) begin
                            t_last  = cyc;
                            in_data = 0;
                        end
                        mon_beat++;
                    end
                end
            end
        end
    end

    // Offer one line; returns ok=1 when it will be accepted at the next edge.
    // wr_req_valid is left high so calls can be chained back to back.
    task automatic offer(input logic [AW-1:0] a, input logic [LW-1:0] d,
                         input logic [LW/8-1:0] m, input int maxc, output bit ok);
        line_t l;
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            wr_req_valid = 1'b1;
            wr_req_addr  = a;
            wr_req_data  = d;
`ifdef MANNIX_DDR_WR_MASK_EN
            wr_req_mask  = m;
`endif
            if (wr_req_ready) begin
                l.addr = a; l.data = d; l.mask = m;
                exp_q.push_back(l);
                t_acc = cyc + 1;
                ok = 1;
                $display("request accepted addr=%08h at cycle %0d", a, t_acc);
                break;
            end
        end
    endtask

    task automatic release_req();
        @(posedge clk);
        #1 wr_req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int maxc);
        for (int i = 0; i < maxc && done_count < target; i++) @(negedge clk);
        @(negedge clk);
        check("done_count", done_count, target);
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_aw_valid"}, ddr_aw_valid, 0);
        check({tag, "_w_valid"}, ddr_w_valid, 0);
        check({tag, "_w_last"}, ddr_w_last, 0);
        check({tag, "_b_ready"}, ddr_b_ready, 0);
        check({tag, "_wr_done"}, wr_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err_sticky, 0);
        check({tag, "_ready"}, wr_req_ready, 0);
        check({tag, "_aw_addr"}, ddr_aw_addr, 0);
        check({tag, "_w_data"}, ddr_w_data, 0);
        check({tag, "_w_strb"}, ddr_w_strb, 0);
    endtask

    initial begin
        logic [LW-1:0]   d;
        logic [LW/8-1:0] m;
        logic [AW-1:0]   a;
        bit ok;
        int accepted, base;
        line_t held;

        rst = 1'b1; wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0;
`ifdef MANNIX_DDR_WR_MASK_EN
        wr_req_mask = '0;
`endif
        err_clr = 1'b0;
        ddr_aw_ready = 1'b0; ddr_w_ready = 1'b0; ddr_b_valid = 1'b0; ddr_b_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", wr_req_ready, 1);

        // Single line, byte pattern, always-ready DDR, latency measured
        mode = 0;
        for (int i = 0; i < LW / 8; i++) d[i*8 +: 8] = 8'(i);
        m = '1;
`ifdef MANNIX_DDR_WR_MASK_EN
        m[31:0] = 32'hFF00_00FF;
`endif
        offer(32'h0000_1000, d, m, 20, ok);
        check("single_accept", ok, 1);
        release_req();
        wait_done(1, 50);
        check("lat_aw", t_aw, t_acc + 1);
        check("lat_beat0", t_beat0, t_acc + 2);
        check("lat_last", t_last, t_acc + 1 + BEATS);
        check("lat_done", t_done, t_acc + BEATS + 3);
        check("single_err", err_sticky, 0);

        // Stalled address channel: FIFO_DEPTH entries plus the one line
        // already popped into the working registers get accepted.
        mode = 2;
        base = done_count;
        accepted = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            held.addr = 32'h0002_0000 + 32'(i * 32);
            held.data = rand_line();
            held.mask = {(LW/8){1'b1}};
            offer(held.addr, held.data, held.mask, 20, ok);
            if (!ok) break;
            accepted++;
        end
        check("stall_accepts", accepted, DEPTH + 1);
        check("stall_ready_low", wr_req_ready, 0);
        mode = 0;
        offer(held.addr, held.data, held.mask, 40, ok);
        check("stall_release_accept", ok, 1);
        release_req();
        wait_done(base + DEPTH + 2, 400);

        // w_ready toggling every cycle
        mode = 3;
        offer(32'h0003_0040, rand_line(), '1, 20, ok);
        release_req();
        wait_done(done_count + 1, 100);

        // Misaligned address, clear, then DDR error response
        mode = 0;
        offer(32'h0000_1004, rand_line(), '1, 20, ok);
        release_req();
        wait_done(done_count + 1, 50);
        check("misaligned_err", err_sticky, 1);
        @(posedge clk);
        #1 err_clr = 1'b1; exp_err = 0;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        check("err_cleared", err_sticky, 0);
        force_berr = 1;
        offer(32'h0000_2000, rand_line(), '1, 20, ok);
        release_req();
        wait_done(done_count + 1, 50);
        force_berr = 0;
        check("berr_sets_err", err_sticky, 1);
        @(posedge clk);
        #1 err_clr = 1'b1; exp_err = 0;
        @(posedge clk);
        #1 err_clr = 1'b0;

        // Reset during beat 2: everything discarded, no wr_done
        base = done_count;
        offer(32'h0004_0000, rand_line(), '1, 20, ok);
        offer(32'h0004_0020, rand_line(), '1, 20, ok);
        release_req();
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (in_data && mon_beat == 2) begin ok = 1; break; end
        end
        check("reached_beat2", ok, 1);
        #1 rst = 1'b1;
        exp_q.delete();
        exp_err = 0;
        @(posedge clk);
        @(negedge clk);
        check_quiet("midreset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midreset_no_done", done_count, base);
        check("midreset_ready", wr_req_ready, 1);
        offer(32'h0005_0000, rand_line(), '1, 20, ok);
        release_req();
        wait_done(base + 1, 50);

        // Randomized traffic against random DDR handshakes
        mode = 1;
        base = done_count;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[OFF-1:0] = '0;
            for (int j = 0; j < LW / 8; j++) m[j] = 1'($urandom_range(0, 1));
            offer(a, rand_line(), m, 200, ok);
            check("rand_accept", ok, 1);
        end
        release_req();
        wait_done(base + 20, 3000);
        mode = 0;
        repeat (3) @(negedge clk);
        check("final_idle", busy, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
